game_control_np: RTL and testbench

- Parametrised successor to the 2-player game control block.
- Counts coins into a saturating credit counter and handles 1..NUM_PLAYERS start buttons.
- Generates the attract/play state and rotates turns among active players until all are out.
- Sits between the coin/start inputs and the playfield/score logic; ATTRACT gates sound and paddle logic as before.

---
 rtl/game_control_np.sv | 193 +++++++++++++++++++
 tb/tb_game_control_np.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_control_np.sv
`default_nettype none
// =============================================================================
// Module   : game_control_np
// Brief    : Coin/credit counter, start arbitration and turn rotation for
//            1..NUM_PLAYERS player coin-op game control.
// Revision : 1.0 - initial release
// =============================================================================
module game_control_np #(
    parameter int NUM_PLAYERS      = 2,
    parameter int NUM_COINS        = 2,
    parameter int CREDIT_W         = 4,
    parameter int MAX_CREDITS      = 9,
    parameter int COINS_PER_CREDIT = 1
) (
    input  logic                   CLK_DRV,
    input  logic                   RESET,
    input  logic [NUM_COINS-1:0]   COIN_N,
    input  logic [NUM_PLAYERS-1:0] START_N,
    input  logic                   FREE_PLAY,
    input  logic                   TURN_END,
    input  logic                   PLAYER_OUT,
    output logic [CREDIT_W-1:0]    CREDITS,
    output logic                   COIN_Q,
    output logic [NUM_PLAYERS-1:0] START_LAMP,
    output logic                   ATTRACT,
    output logic                   ATTRACT_N,
    output logic                   START_GAME,
    output logic [2:0]             GAME_PLAYERS,
    output logic [2:0]             CUR_PLAYER,
    output logic [NUM_PLAYERS-1:0] ACTIVE_MASK
);

    localparam int                  c_ACC_W = 8;
    localparam logic [c_ACC_W-1:0]  c_CPC   = c_ACC_W'(COINS_PER_CREDIT);
    localparam logic [CREDIT_W:0]   c_MAX   = (CREDIT_W+1)'(MAX_CREDITS);

    typedef enum logic [1:0] {
        ST_ATTRACT = 2'd0,
        ST_PLAY    = 2'd1,
        ST_OVER    = 2'd2
    } state_t;

    state_t                   r_state, w_state_next;
    logic                     r_attract, r_start_game, w_start_game_next;
    logic [2:0]               r_players, w_players_next, r_cur, w_cur_next;
    logic [NUM_PLAYERS-1:0]   r_mask, w_mask_next, w_cleared;
    logic [CREDIT_W-1:0]      r_credits, w_credits_next;
    logic [CREDIT_W:0]        w_cred_sum, w_deduct;
    logic [c_ACC_W-1:0]       r_acc, w_acc_next, w_acc_sum, w_coin_cnt;
    logic                     w_credit_inc, w_start_hit;
    logic [2:0]               w_start_k;

    logic [NUM_COINS-1:0]     r_coin_s1, r_coin_s2, r_coin_prev, w_coin_ev;
    logic [NUM_PLAYERS-1:0]   r_start_s1, r_start_s2, r_start_prev, w_start_ev;

    // History keeps following the synchronised pin through reset, so a switch
    // held across reset is already "seen" and cannot produce a fresh press.
    always_ff @(posedge CLK_DRV) begin
        r_coin_s1    <= COIN_N;
        r_coin_s2    <= r_coin_s1;
        r_coin_prev  <= r_coin_s2;
        r_start_s1   <= START_N;
        r_start_s2   <= r_start_s1;
        r_start_prev <= r_start_s2;
    end

    assign w_coin_ev  = r_coin_prev & ~r_coin_s2;
    assign w_start_ev = r_start_prev & ~r_start_s2;

    // Next player: nearest set bit strictly after cur, cyclically.
    function automatic logic [2:0] f_next_player(input logic [NUM_PLAYERS-1:0] mask,
                                                 input logic [2:0] cur);
        logic [2:0] best;
        int         best_d;
        int         d;
        best   = cur;
        best_d = NUM_PLAYERS + 1;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            d = j - int'(cur);
            if (d <= 0) d = d + NUM_PLAYERS;
            if (mask[j] && (d < best_d)) begin
                best_d = d;
                best   = 3'(j);
            end
        end
        return best;
    endfunction

    always_comb begin
        w_coin_cnt = '0;
        for (int i = 0; i < NUM_COINS; i++)
            w_coin_cnt = w_coin_cnt + c_ACC_W'(w_coin_ev[i]);
        w_acc_sum    = r_acc + w_coin_cnt;
        w_credit_inc = (w_acc_sum >= c_CPC);
        w_acc_next   = w_credit_inc ? (w_acc_sum - c_CPC) : w_acc_sum;

        // Later iterations overwrite earlier ones: highest eligible button wins.
        w_start_hit = 1'b0;
        w_start_k   = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (w_start_ev[k] && (FREE_PLAY || (int'(r_credits) >= k + 1))) begin
                w_start_hit = 1'b1;
                w_start_k   = 3'(k);
            end
        end

        w_cleared = r_mask;
        for (int i = 0; i < NUM_PLAYERS; i++)
            w_cleared[i] = r_mask[i] && (3'(i) != r_cur);
    end

    always_comb begin
        w_state_next      = r_state;
        w_players_next    = r_players;
        w_cur_next        = r_cur;
        w_mask_next       = r_mask;
        w_start_game_next = 1'b0;
        w_deduct          = '0;
        case (r_state)
            ST_ATTRACT: begin
                if (w_start_hit) begin
                    w_state_next      = ST_PLAY;
                    w_players_next    = w_start_k + 3'd1;
                    w_cur_next        = '0;
                    w_start_game_next = 1'b1;
                    for (int i = 0; i < NUM_PLAYERS; i++)
                        w_mask_next[i] = (3'(i) <= w_start_k);
                    if (!FREE_PLAY)
                        w_deduct = (CREDIT_W+1)'(w_start_k) + (CREDIT_W+1)'(1);
                end
            end
            ST_PLAY: begin
                if (PLAYER_OUT) begin
                    w_mask_next = w_cleared;
                    if (w_cleared == '0) w_state_next = ST_OVER;
                    else                 w_cur_next   = f_next_player(w_cleared, r_cur);
                end else if (TURN_END) begin
                    w_cur_next = f_next_player(r_mask, r_cur);
                end
            end
            ST_OVER: begin
                w_state_next   = ST_ATTRACT;
                w_players_next = '0;
                w_cur_next     = '0;
                w_mask_next    = '0;
            end
            default: w_state_next = ST_ATTRACT;
        endcase

        // Deduct never exceeds the current count, so the sum cannot underflow.
        w_cred_sum     = {1'b0, r_credits} + (CREDIT_W+1)'(w_credit_inc) - w_deduct;
        w_credits_next = (w_cred_sum > c_MAX) ? c_MAX[CREDIT_W-1:0] : w_cred_sum[CREDIT_W-1:0];
    end

    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            r_state      <= ST_ATTRACT;
            r_attract    <= 1'b1;
            r_start_game <= 1'b0;
            r_players    <= '0;
            r_cur        <= '0;
            r_mask       <= '0;
            r_credits    <= '0;
            r_acc        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_attract    <= (w_state_next != ST_PLAY);
            r_start_game <= w_start_game_next;
            r_players    <= w_players_next;
            r_cur        <= w_cur_next;
            r_mask       <= w_mask_next;
            r_credits    <= w_credits_next;
            r_acc        <= w_acc_next;
        end
    end

    assign CREDITS      = r_credits;
    assign COIN_Q       = (r_credits != '0) || FREE_PLAY;
    assign ATTRACT      = r_attract;
    assign ATTRACT_N    = ~r_attract;
    assign START_GAME   = r_start_game;
    assign GAME_PLAYERS = r_players;
    assign CUR_PLAYER   = r_cur;
    assign ACTIVE_MASK  = r_mask;

    generate
        for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_lamp
            assign START_LAMP[k] = r_attract && (FREE_PLAY || (r_credits >= CREDIT_W'(k + 1)));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_game_control_np.sv
`default_nettype none
// =============================================================================
// Module   : tb_game_control_np
// Brief    : Self-checking bench for game_control_np (2-player default and a
//            4-player, 2-coins-per-credit instance).
// Revision : 1.0 - initial release
// =============================================================================
module tb_game_control_np;

    logic CLK_DRV = 1'b0;
    always #5 CLK_DRV = ~CLK_DRV;

    logic       RESET, FREE_PLAY, TURN_END, PLAYER_OUT;
    logic [1:0] COIN_N, START_N;
    logic [3:0] CREDITS;
    logic       COIN_Q, ATTRACT, ATTRACT_N, START_GAME;
    logic [1:0] START_LAMP, ACTIVE_MASK;
    logic [2:0] GAME_PLAYERS, CUR_PLAYER;

    logic [1:0] COIN4_N;
    logic [3:0] START4_N, CREDITS4, START_LAMP4, MASK4;
    logic       COIN_Q4, ATTRACT4, ATTRACT_N4, START_GAME4;
    logic [2:0] GP4, CUR4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int   m_credits, m_acc, m_gp, m_cur, m_mask;
    logic m_attract;

    game_control_np #(.NUM_PLAYERS(2), .NUM_COINS(2), .CREDIT_W(4),
                      .MAX_CREDITS(9), .COINS_PER_CREDIT(1)) dut (
        .CLK_DRV(CLK_DRV), .RESET(RESET), .COIN_N(COIN_N), .START_N(START_N),
        .FREE_PLAY(FREE_PLAY), .TURN_END(TURN_END), .PLAYER_OUT(PLAYER_OUT),
        .CREDITS(CREDITS), .COIN_Q(COIN_Q), .START_LAMP(START_LAMP),
        .ATTRACT(ATTRACT), .ATTRACT_N(ATTRACT_N), .START_GAME(START_GAME),
        .GAME_PLAYERS(GAME_PLAYERS), .CUR_PLAYER(CUR_PLAYER), .ACTIVE_MASK(ACTIVE_MASK)
    );

    game_control_np #(.NUM_PLAYERS(4), .NUM_COINS(2), .CREDIT_W(4),
                      .MAX_CREDITS(9), .COINS_PER_CREDIT(2)) dut4 (
        .CLK_DRV(CLK_DRV), .RESET(RESET), .COIN_N(COIN4_N), .START_N(START4_N),
        .FREE_PLAY(FREE_PLAY), .TURN_END(TURN_END), .PLAYER_OUT(PLAYER_OUT),
        .CREDITS(CREDITS4), .COIN_Q(COIN_Q4), .START_LAMP(START_LAMP4),
        .ATTRACT(ATTRACT4), .ATTRACT_N(ATTRACT_N4), .START_GAME(START_GAME4),
        .GAME_PLAYERS(GP4), .CUR_PLAYER(CUR4), .ACTIVE_MASK(MASK4)
    );

    function automatic void m_reset();
        m_credits = 0; m_acc = 0; m_gp = 0; m_cur = 0; m_mask = 0; m_attract = 1'b1;
    endfunction

    function automatic void m_coins(input int n);
        m_acc = m_acc + n;
        while (m_acc >= 1) begin
            m_acc = m_acc - 1;
            if (m_credits < 9) m_credits = m_credits + 1;
        end
    endfunction

    function automatic bit m_start(input int k);
        if (m_attract && (m_credits >= k + 1 || FREE_PLAY)) begin
            if (!FREE_PLAY) m_credits = m_credits - (k + 1);
            m_gp = k + 1; m_mask = (1 << (k + 1)) - 1; m_cur = 0; m_attract = 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void m_advance();
        int p;
        for (int off = 1; off <= m_gp; off++) begin
            p = (m_cur + off) % m_gp;
            if (((m_mask >> p) & 1) == 1) begin
                m_cur = p;
                return;
            end
        end
    endfunction

    function automatic bit m_pulse(input bit te, input bit po);
        if (m_attract) return 1'b0;
        if (po) begin
            m_mask = m_mask & ~(1 << m_cur);
            if (m_mask == 0) begin
                m_attract = 1'b1;
                return 1'b1;
            end
            m_advance();
        end else if (te) begin
            m_advance();
        end
        return 1'b0;
    endfunction

    function automatic logic [16:0] exp_vec();
        logic [1:0] lamp;
        for (int k = 0; k < 2; k++) lamp[k] = m_attract && (m_credits >= k + 1 || FREE_PLAY);
        return {4'(m_credits), m_attract, ~m_attract, 3'(m_gp), 3'(m_cur), 2'(m_mask),
                (m_credits != 0) || FREE_PLAY, lamp};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {CREDITS, ATTRACT, ATTRACT_N, GAME_PLAYERS, CUR_PLAYER, ACTIVE_MASK, COIN_Q, START_LAMP};
    endfunction

    task automatic do_reset();
        RESET = 1'b1; COIN_N = '1; START_N = '1; COIN4_N = '1; START4_N = '1;
        TURN_END = 1'b0; PLAYER_OUT = 1'b0;
        repeat (3) @(negedge CLK_DRV);
        RESET = 1'b0;
        m_reset();
        @(negedge CLK_DRV);
    endtask

    task automatic drop_coins(input logic [1:0] which);
        @(negedge CLK_DRV); COIN_N = ~which;
        repeat (3) @(negedge CLK_DRV); COIN_N = '1;
        repeat (3) @(negedge CLK_DRV);
    endtask

    task automatic press_start(input int k, output int pulses);
        @(negedge CLK_DRV); START_N = ~(2'(1) << k);
        pulses = 0;
        repeat (6) begin
            @(negedge CLK_DRV);
            if (START_GAME) pulses++;
        end
        START_N = '1;
        repeat (3) @(negedge CLK_DRV);
    endtask

    task automatic pulse(input logic te, input logic po);
        @(negedge CLK_DRV); TURN_END = te; PLAYER_OUT = po;
        @(negedge CLK_DRV); TURN_END = 1'b0; PLAYER_OUT = 1'b0;
    endtask

    task automatic test_reset();
        FREE_PLAY = 1'b0;
        do_reset();
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_vec: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        n_checks++;
        if (START_GAME !== 1'b0) $display("FAIL reset_start_game: got %b expected 0", START_GAME);
        else n_pass++;
    endtask

    task automatic test_coin();
        do_reset();
        @(negedge CLK_DRV); COIN_N = 2'b10;
        repeat (2) @(negedge CLK_DRV);
        n_checks++;
        if (CREDITS !== 4'(m_credits)) $display("FAIL coin_early: got %0d expected %0d", CREDITS, m_credits);
        else n_pass++;
        @(negedge CLK_DRV);
        m_coins(1);
        n_checks++;
        if (CREDITS !== 4'(m_credits)) $display("FAIL coin_latency: got %0d expected %0d", CREDITS, m_credits);
        else n_pass++;
        repeat (2) @(negedge CLK_DRV); COIN_N = '1;
        repeat (4) @(negedge CLK_DRV);
        n_checks++;
        if (CREDITS !== 4'(m_credits)) $display("FAIL coin_held: got %0d expected %0d", CREDITS, m_credits);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drop_coins(2'(1) << $urandom_range(0, 1));
            m_coins(1);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL coin_vec: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_start_eligibility();
        int p;
        int e;
        do_reset();
        drop_coins(2'b01); m_coins(1);
        press_start(1, p);
        e = m_start(1) ? 1 : 0;
        n_checks++;
        if (p !== e) $display("FAIL start_inelig_pulse: got %0d expected %0d", p, e);
        else n_pass++;
        press_start(0, p);
        e = m_start(0) ? 1 : 0;
        n_checks++;
        if (p !== e) $display("FAIL start_pulse: got %0d expected %0d", p, e);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL start_vec: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        pulse(1'b0, 1'b1);
        void'(m_pulse(1'b0, 1'b1));
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL over_vec: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        @(negedge CLK_DRV);
        m_gp = 0; m_cur = 0;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL attract_vec: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_two_player();
        int p;
        int e;
        do_reset();
        drop_coins(2'b11); m_coins(2);
        press_start(1, p);
        e = m_start(1) ? 1 : 0;
        n_checks++;
        if (p !== e || obs_vec() !== exp_vec())
            $display("FAIL two_start: pulses %0d vec %h expected pulses %0d vec %h", p, obs_vec(), e, exp_vec());
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            // three turn ends, one player out, then both pulses together
            logic te, po;
            bit over;
            te = (i != 3); po = (i >= 3);
            pulse(te, po);
            over = m_pulse(te, po);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL two_turn%0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (over) begin
                @(negedge CLK_DRV);
                m_gp = 0; m_cur = 0;
                n_checks++;
                if (obs_vec() !== exp_vec()) $display("FAIL two_attract: got %h expected %h", obs_vec(), exp_vec());
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        int p;
        int e;
        do_reset();
        repeat (9) begin drop_coins(2'b01); m_coins(1); end
        drop_coins(2'b11); m_coins(2);
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL sat_vec: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        do_reset();
        drop_coins(2'b01); m_coins(1);
        for (int pass = 0; pass < 2; pass++) begin
            // same-cycle coin + 2-player start: ineligible at 1 credit, eligible at 2
            @(negedge CLK_DRV); COIN_N = 2'b10; START_N = 2'b01;
            p = 0;
            repeat (6) begin
                @(negedge CLK_DRV);
                if (START_GAME) p++;
            end
            COIN_N = '1; START_N = '1;
            repeat (3) @(negedge CLK_DRV);
            e = m_start(1) ? 1 : 0;
            m_coins(1);
            n_checks++;
            if (p !== e || obs_vec() !== exp_vec())
                $display("FAIL coin_start%0d: pulses %0d vec %h expected pulses %0d vec %h", pass, p, obs_vec(), e, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_free_play();
        int p;
        int e;
        FREE_PLAY = 1'b1;
        do_reset();
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL fp_reset: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
        press_start(1, p);
        e = m_start(1) ? 1 : 0;
        n_checks++;
        if (p !== e || obs_vec() !== exp_vec())
            $display("FAIL fp_start: pulses %0d vec %h expected pulses %0d vec %h", p, obs_vec(), e, exp_vec());
        else n_pass++;
        @(negedge CLK_DRV); START_N = 2'b10;
        repeat (2) @(negedge CLK_DRV);
        RESET = 1'b1;
        repeat (4) @(negedge CLK_DRV);
        RESET = 1'b0;
        m_reset();
        p = 0;
        repeat (8) begin
            @(negedge CLK_DRV);
            if (START_GAME) p++;
        end
        n_checks++;
        if (p !== 0 || obs_vec() !== exp_vec())
            $display("FAIL held_reset: pulses %0d vec %h expected pulses 0 vec %h", p, obs_vec(), exp_vec());
        else n_pass++;
        START_N = '1;
        repeat (3) @(negedge CLK_DRV);
        press_start(0, p);
        e = m_start(0) ? 1 : 0;
        n_checks++;
        if (p !== e || obs_vec() !== exp_vec())
            $display("FAIL fp_restart: pulses %0d vec %h expected pulses %0d vec %h", p, obs_vec(), e, exp_vec());
        else n_pass++;
        FREE_PLAY = 1'b0;
    endtask

    task automatic test_random();
        int         op, p, e;
        logic [1:0] which;
        bit         over;
        FREE_PLAY = 1'b0;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            FREE_PLAY = ($urandom_range(0, 5) == 0);
            op   = $urandom_range(0, 5);
            over = 1'b0;
            case (op)
                0, 1: begin
                    which = 2'($urandom_range(1, 3));
                    drop_coins(which);
                    m_coins(int'(which[0]) + int'(which[1]));
                end
                2: begin
                    e = $urandom_range(0, 1);
                    press_start(e, p);
                    e = m_start(e) ? 1 : 0;
                    n_checks++;
                    if (p !== e) $display("FAIL rnd_pulse%0d: got %0d expected %0d", it, p, e);
                    else n_pass++;
                end
                default: begin
                    pulse(op != 4, op != 3);
                    over = m_pulse(op != 4, op != 3);
                end
            endcase
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL rnd_vec%0d: got %h expected %h", it, obs_vec(), exp_vec());
            else n_pass++;
            if (over) begin
                @(negedge CLK_DRV);
                m_gp = 0; m_cur = 0;
                n_checks++;
                if (obs_vec() !== exp_vec()) $display("FAIL rnd_attract%0d: got %h expected %h", it, obs_vec(), exp_vec());
                else n_pass++;
            end
        end
        FREE_PLAY = 1'b0;
    endtask

    task automatic test_four_player();
        int         p;
        logic [2:0] exp_cur [5];
        bit         po_seq  [5];
        exp_cur = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd2};
        po_seq  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        FREE_PLAY = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK_DRV); COIN4_N = 2'b10;
            repeat (3) @(negedge CLK_DRV); COIN4_N = '1;
            repeat (3) @(negedge CLK_DRV);
            if (i == 4) begin
                n_checks++;
                if (CREDITS4 !== 4'd2) $display("FAIL p4_five_coins: got %0d expected 2", CREDITS4);
                else n_pass++;
                @(negedge CLK_DRV); START4_N = 4'b0111;
                p = 0;
                repeat (6) begin
                    @(negedge CLK_DRV);
                    if (START_GAME4) p++;
                end
                START4_N = '1;
                repeat (3) @(negedge CLK_DRV);
                n_checks++;
                if (p !== 0 || {CREDITS4, ATTRACT4} !== {4'd2, 1'b1})
                    $display("FAIL p4_inelig: pulses %0d credits %0d attract %b expected 0 2 1", p, CREDITS4, ATTRACT4);
                else n_pass++;
            end
        end
        n_checks++;
        if ({CREDITS4, START_LAMP4} !== {4'd4, 4'b1111})
            $display("FAIL p4_eight_coins: credits %0d lamp %b expected 4 1111", CREDITS4, START_LAMP4);
        else n_pass++;
        @(negedge CLK_DRV); START4_N = 4'b0111;
        p = 0;
        repeat (6) begin
            @(negedge CLK_DRV);
            if (START_GAME4) p++;
        end
        START4_N = '1;
        repeat (3) @(negedge CLK_DRV);
        n_checks++;
        if (p !== 1 || {CREDITS4, GP4, MASK4, CUR4, ATTRACT4} !== {4'd0, 3'd4, 4'b1111, 3'd0, 1'b0})
            $display("FAIL p4_start: pulses %0d state %h expected 1 %h", p,
                     {CREDITS4, GP4, MASK4, CUR4, ATTRACT4}, {4'd0, 3'd4, 4'b1111, 3'd0, 1'b0});
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            pulse(!po_seq[i], po_seq[i]);
            n_checks++;
            if (CUR4 !== exp_cur[i]) $display("FAIL p4_rot%0d: got %0d expected %0d", i, CUR4, exp_cur[i]);
            else n_pass++;
        end
        n_checks++;
        if (MASK4 !== 4'b1101) $display("FAIL p4_mask: got %b expected 1101", MASK4);
        else n_pass++;
    endtask

    initial begin
        RESET = 1'b1; FREE_PLAY = 1'b0; TURN_END = 1'b0; PLAYER_OUT = 1'b0;
        COIN_N = '1; START_N = '1; COIN4_N = '1; START4_N = '1;
        m_reset();
        test_reset();
        test_coin();
        test_start_eligibility();
        test_two_player();
        test_saturation();
        test_free_play();
        test_random();
        test_four_player();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
